// File: rtl/toeplitz_pkg.sv
// Constants and state encoding shared by the Toeplitz hash pipeline
// (row-shift stage, row accumulator, result writer).
package toeplitz_pkg;

    localparam int DATA_W    = 3072;            // width of the hash result
    localparam int WORD_W    = 32;              // output word width
    localparam int NUM_WORDS = DATA_W / WORD_W; // words per frame (96)
    localparam int ADDR_W    = 7;               // word-address width

    // Result-writer FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/toeplitz_result_writer_wide_shift_serializer.sv
// Wide load/shift register that presents a DATA_W result one WORD_W word at a
// time, most significant word first, along with the index of the current word.
module wide_shift_serializer
    import toeplitz_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              load,      // capture din, restart at word 0
    input  logic              shift,     // current word accepted, advance
    input  logic [DATA_W-1:0] din,
    output logic [WORD_W-1:0] word,
    output logic [ADDR_W-1:0] word_idx,
    output logic              last       // current word is the final one
);

    logic [DATA_W-1:0] buffer_q, buffer_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;

    // Next buffer/index: load wins over shift; shifting left exposes the next word at the top.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch inferred.
        buffer_d   = buffer_q;
        word_idx_d = word_idx_q;
        if (load) begin
            buffer_d   = din;
            word_idx_d = '0;
        end else if (shift) begin
            buffer_d   = buffer_q << WORD_W;
            word_idx_d = word_idx_q + 1'b1;
        end
    end

    // Buffer and index registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the wide buffer is reset on purpose -- wr_data comes straight from it and must never show X.
            buffer_q   <= '0;
            word_idx_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            buffer_q   <= buffer_d;
            word_idx_q <= word_idx_d;
        end
    end

    assign word     = buffer_q[DATA_W-1 -: WORD_W];
    assign word_idx = word_idx_q;
    assign last     = (word_idx_q == ADDR_W'(NUM_WORDS - 1));

endmodule

// File: rtl/toeplitz_result_writer.sv
// Captures the accumulator's hash result on write_en and streams it out as
// NUM_WORDS addressed words over a valid/ready port. Counts completed frames
// and flags (sticky) any result that arrives while a frame is still in flight.
module toeplitz_result_writer
    import toeplitz_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] final_result,
    input  logic              write_en,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [WORD_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic [15:0]       frame_cnt
);

    state_e            state_q, state_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic              load;
    logic              shift;
    logic              last;
    logic [ADDR_W-1:0] word_idx;

    wide_shift_serializer u_ser (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .load     (load),
        .shift    (shift),
        .din      (final_result),
        .word     (wr_data),
        .word_idx (word_idx),
        .last     (last)
    );

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: capture in IDLE, leave SEND after the last accepted word, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (write_en)          state_d = ST_SEND;
            ST_SEND: if (wr_ready && last)  state_d = ST_DONE;
            ST_DONE:                        state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: valid is held through backpressure; address is only meaningful while sending.
    always_comb begin
        wr_valid   = (state_q == ST_SEND);
        busy       = (state_q != ST_IDLE);
        frame_done = (state_q == ST_DONE);
        load       = (state_q == ST_IDLE) && write_en;
        shift      = wr_valid && wr_ready;
        wr_addr    = wr_valid ? ADDR_W'(BASE_ADDR + word_idx) : '0;
    end

    // Status next values: results arriving while busy are dropped and flagged; count frames on DONE.
    always_comb begin
        overflow_d  = overflow_q | (write_en && (state_q != ST_IDLE));
        frame_cnt_d = frame_cnt_q;
        if (state_q == ST_DONE) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // Status registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_toeplitz_result_writer.sv
// Self-checking bench for toeplitz_result_writer. A frame is described as an
// array of NUM_WORDS words (word 0 most significant); the bench packs it into
// the wide result and expects the same words back in order at BASE+k.
module tb_toeplitz_result_writer;
    import toeplitz_pkg::*;

    logic              clk_in = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] final_result;
    logic              write_en, write_en_b, wr_ready;

    logic              a_wr_valid, a_busy, a_frame_done, a_overflow;
    logic [WORD_W-1:0] a_wr_data;
    logic [ADDR_W-1:0] a_wr_addr;
    logic [15:0]       a_frame_cnt;
    logic              b_wr_valid, b_busy, b_frame_done, b_overflow;
    logic [WORD_W-1:0] b_wr_data;
    logic [ADDR_W-1:0] b_wr_addr;
    logic [15:0]       b_frame_cnt;

    always #5 clk_in = ~clk_in;

    toeplitz_result_writer dut (
        .clk_in(clk_in), .rst_n(rst_n), .final_result(final_result), .write_en(write_en),
        .wr_valid(a_wr_valid), .wr_ready(wr_ready), .wr_data(a_wr_data), .wr_addr(a_wr_addr),
        .busy(a_busy), .frame_done(a_frame_done), .overflow(a_overflow), .frame_cnt(a_frame_cnt)
    );

    toeplitz_result_writer #(.BASE_ADDR(7'h10)) dut_b (
        .clk_in(clk_in), .rst_n(rst_n), .final_result(final_result), .write_en(write_en_b),
        .wr_valid(b_wr_valid), .wr_ready(wr_ready), .wr_data(b_wr_data), .wr_addr(b_wr_addr),
        .busy(b_busy), .frame_done(b_frame_done), .overflow(b_overflow), .frame_cnt(b_frame_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state.
    logic [WORD_W-1:0] exp_words [NUM_WORDS];
    logic [WORD_W-1:0] got_data [$];
    logic [ADDR_W-1:0] got_addr [$];
    int done_cnt, done_gap, stall_bad, busy_bad;
    int inj_beat = -1;
    bit inj_done = 1'b0;

    task automatic build_frame(input bit incrementing);
        for (int k = 0; k < NUM_WORDS; k++)
            exp_words[k] = incrementing ? 32'hA500_0000 + 32'(k) : 32'($urandom);
    endtask

    function automatic logic [DATA_W-1:0] pack_words();
        logic [DATA_W-1:0] r = '0;
        for (int k = 0; k < NUM_WORDS; k++)
            r[DATA_W-1-WORD_W*k -: WORD_W] = exp_words[k];
        return r;
    endfunction

    // Number of beats that disagree with the model, plus any missing/extra beats.
    function automatic int frame_errors(input logic [ADDR_W-1:0] base);
        int errs = 0;
        int n = (got_data.size() < NUM_WORDS) ? got_data.size() : NUM_WORDS;
        errs += (got_data.size() > NUM_WORDS) ? got_data.size() - NUM_WORDS : NUM_WORDS - got_data.size();
        for (int k = 0; k < n; k++) begin
            if (got_data[k] !== exp_words[k]) errs++;
            if (got_addr[k] !== ADDR_W'(int'(base) + k)) errs++;
        end
        return errs;
    endfunction

    // Pulse write_en for one cycle from an IDLE negedge; checks the one-cycle valid latency.
    task automatic send_result(input bit use_b, input logic [DATA_W-1:0] value);
        logic v;
        v = use_b ? b_wr_valid : a_wr_valid;
        n_total++;
        if (v !== 1'b0) $display("FAIL pre_capture_valid: got %b expected 0", v);
        else n_pass++;
        final_result = value;
        if (use_b) write_en_b = 1'b1; else write_en = 1'b1;
        @(negedge clk_in);
        write_en   = 1'b0;
        write_en_b = 1'b0;
        v = use_b ? b_wr_valid : a_wr_valid;
        n_total++;
        if (v !== 1'b1) $display("FAIL valid_latency: got %b expected 1", v);
        else n_pass++;
    endtask

    // Act as the sink until frame_done (or the budget expires); returns at the first IDLE negedge.
    task automatic drain(input bit use_b, input bit rand_ready, input int budget);
        logic v, fd, bz, pv;
        logic [WORD_W-1:0] d, pd;
        logic [ADDR_W-1:0] a, pa;
        int cyc = 0;
        int last_beat = -10;
        pv = 1'b0; pd = '0; pa = '0;
        got_data.delete(); got_addr.delete();
        done_cnt = 0; done_gap = -1; stall_bad = 0; busy_bad = 0;
        while (cyc < budget) begin
            v  = use_b ? b_wr_valid   : a_wr_valid;
            d  = use_b ? b_wr_data    : a_wr_data;
            a  = use_b ? b_wr_addr    : a_wr_addr;
            fd = use_b ? b_frame_done : a_frame_done;
            bz = use_b ? b_busy       : a_busy;
            if (pv && (!v || d !== pd || a !== pa)) stall_bad++;
            if (v && !bz) busy_bad++;
            write_en = 1'b0;
            if (!use_b && v && inj_beat >= 0 && got_data.size() == inj_beat) begin
                final_result = '1;
                write_en     = 1'b1;
            end
            if (fd) begin
                done_cnt++;
                done_gap = cyc - last_beat;
                if (!bz) busy_bad++;
                if (!use_b && inj_done) begin
                    final_result = '1;
                    write_en     = 1'b1;
                end
            end
            wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v && wr_ready) begin
                got_data.push_back(d);
                got_addr.push_back(a);
                last_beat = cyc;
            end
            pv = v && !wr_ready;
            pd = d;
            pa = a;
            @(negedge clk_in);
            cyc++;
            if (fd) begin
                write_en = 1'b0;
                if (use_b ? b_busy : a_busy) busy_bad++;
                if (use_b ? b_frame_done : a_frame_done) done_cnt++;
                break;
            end
        end
        write_en = 1'b0;
        wr_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; write_en = 1'b0; write_en_b = 1'b0; wr_ready = 1'b0; final_result = '0;
        repeat (3) @(negedge clk_in);
        n_total++;
        if ({a_wr_valid, a_busy, a_frame_done, a_overflow, a_frame_cnt, a_wr_addr, a_wr_data} !== '0)
            $display("FAIL reset_outputs_a: valid=%b busy=%b done=%b ovf=%b cnt=%h addr=%h data=%h expected all 0",
                     a_wr_valid, a_busy, a_frame_done, a_overflow, a_frame_cnt, a_wr_addr, a_wr_data);
        else n_pass++;
        n_total++;
        if ({b_wr_valid, b_busy, b_frame_done, b_overflow, b_frame_cnt, b_wr_addr, b_wr_data} !== '0)
            $display("FAIL reset_outputs_b: valid=%b busy=%b addr=%h expected all 0", b_wr_valid, b_busy, b_wr_addr);
        else n_pass++;
        rst_n = 1'b1;
        wr_ready = 1'b1;
        repeat (2) @(negedge clk_in);
        n_total++;
        if ({a_wr_valid, a_busy, a_frame_cnt} !== '0)
            $display("FAIL idle_after_reset: valid=%b busy=%b cnt=%h expected 0", a_wr_valid, a_busy, a_frame_cnt);
        else n_pass++;
    endtask

    task automatic check_frame(input string name, input logic [ADDR_W-1:0] base, input bit use_b,
                               input logic [15:0] exp_cnt);
        int e;
        logic [15:0] cnt;
        e = frame_errors(base);
        n_total++;
        if (e !== 0) $display("FAIL %s_frame: got %0d bad/missing beats of %0d received, expected 0", name, e, got_data.size());
        else n_pass++;
        n_total++;
        if (done_cnt !== 1) $display("FAIL %s_done_pulses: got %0d expected 1", name, done_cnt);
        else n_pass++;
        n_total++;
        if (stall_bad !== 0 || busy_bad !== 0)
            $display("FAIL %s_stability: got stall_bad=%0d busy_bad=%0d expected 0", name, stall_bad, busy_bad);
        else n_pass++;
        cnt = use_b ? b_frame_cnt : a_frame_cnt;
        n_total++;
        if (cnt !== exp_cnt) $display("FAIL %s_frame_cnt: got %0d expected %0d", name, cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        build_frame(1'b1);
        send_result(1'b0, pack_words());
        drain(1'b0, 1'b0, 300);
        check_frame("b2b", 7'h00, 1'b0, 16'd1);
        n_total++;
        if (done_gap !== 1) $display("FAIL b2b_done_gap: got %0d expected 1", done_gap);
        else n_pass++;
        n_total++;
        if (a_overflow !== 1'b0) $display("FAIL b2b_overflow: got %b expected 0", a_overflow);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        build_frame(1'b0);
        send_result(1'b0, pack_words());
        drain(1'b0, 1'b1, 2000);
        check_frame("backpressure", 7'h00, 1'b0, 16'd2);
    endtask

    // Starts in the first IDLE cycle after the previous frame_done.
    task automatic test_rearm();
        build_frame(1'b0);
        send_result(1'b0, pack_words());
        drain(1'b0, 1'b0, 300);
        check_frame("rearm", 7'h00, 1'b0, 16'd3);
        n_total++;
        if (a_overflow !== 1'b0) $display("FAIL rearm_overflow: got %b expected 0", a_overflow);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int stray = 0;
        build_frame(1'b0);
        inj_beat = 40;
        inj_done = 1'b1;
        send_result(1'b0, pack_words());
        drain(1'b0, 1'b0, 300);
        inj_beat = -1;
        inj_done = 1'b0;
        check_frame("overflow", 7'h00, 1'b0, 16'd4);
        n_total++;
        if (a_overflow !== 1'b1) $display("FAIL overflow_set: got %b expected 1", a_overflow);
        else n_pass++;
        for (int i = 0; i < 120; i++) begin
            if (a_wr_valid !== 1'b0) stray++;
            @(negedge clk_in);
        end
        n_total++;
        if (stray !== 0) $display("FAIL overflow_dropped: got %0d stray valid cycles expected 0", stray);
        else n_pass++;
        n_total++;
        if (a_overflow !== 1'b1 || a_frame_cnt !== 16'd4)
            $display("FAIL overflow_sticky: got ovf=%b cnt=%0d expected ovf=1 cnt=4", a_overflow, a_frame_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int cyc = 0;
        build_frame(1'b0);
        send_result(1'b0, pack_words());
        wr_ready = 1'b1;
        while (a_wr_addr !== 7'd50 && cyc < 200) begin
            @(negedge clk_in);
            cyc++;
        end
        n_total++;
        if (a_wr_addr !== 7'd50) $display("FAIL midreset_reach_word50: got addr %0d expected 50", a_wr_addr);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({a_wr_valid, a_busy, a_frame_done, a_overflow, a_frame_cnt} !== '0)
            $display("FAIL midreset_async: valid=%b busy=%b done=%b ovf=%b cnt=%0d expected all 0",
                     a_wr_valid, a_busy, a_frame_done, a_overflow, a_frame_cnt);
        else n_pass++;
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        n_total++;
        if (a_frame_done !== 1'b0 || a_frame_cnt !== 16'd0)
            $display("FAIL midreset_no_done: got done=%b cnt=%0d expected 0", a_frame_done, a_frame_cnt);
        else n_pass++;
        build_frame(1'b1);
        send_result(1'b0, pack_words());
        drain(1'b0, 1'b0, 300);
        check_frame("after_reset", 7'h00, 1'b0, 16'd1);
    endtask

    task automatic test_base_addr();
        build_frame(1'b0);
        send_result(1'b1, pack_words());
        drain(1'b1, 1'b1, 2000);
        check_frame("base_addr", 7'h10, 1'b1, 16'd1);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_rearm();
        test_overflow();
        test_reset_mid_frame();
        test_base_addr();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
